gen2_backscatter_enc: RTL and testbench

Parametrised Gen2 tag backscatter encoder. It is the successor of the existing FM0/Miller modulator. It generates the complete reply waveform on its own: optional pilot tone, the FM0 or Miller preamble, handshaked payload bits and the dummy-1 terminator. Miller subcarrier depth is configurable. It sits between the tag output control unit (bit source) and the backscatter driver, and is paced by the BLF half-period tick.

---
 rtl/gen2_mod_pkg.sv | 29 ++
 rtl/gen2_bit_source.sv | 67 ++++++
 rtl/gen2_backscatter_enc.sv | 173 +++++++++++++++++
 tb/tb_gen2_backscatter_enc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen2_mod_pkg.sv
// Shared encodings, state type and preamble patterns for the Gen2 backscatter encoder.
package gen2_mod_pkg;

    localparam logic [1:0] M_DEC_FM0 = 2'b00;
    localparam logic [1:0] M_DEC_M2  = 2'b01;
    localparam logic [1:0] M_DEC_M4  = 2'b10;
    localparam logic [1:0] M_DEC_M8  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PILOT,
        ST_PREAMBLE,
        ST_DATA,
        ST_DUMMY,
        ST_DONE
    } enc_state_t;

    localparam logic [11:0] FM0_PREAMBLE    = 12'b110100100011;
    localparam logic [5:0]  MILLER_PREAMBLE = 6'b010111;
    localparam int          PRE_BITS        = 6;

    // Miller factors beyond what the instance supports fall back to the largest one.
    function automatic logic [1:0] clamp_m_log2(input logic [1:0] m_dec, input int max_log2);
        if (int'(m_dec) > max_log2)
            return 2'(max_log2);
        return m_dec;
    endfunction

endpackage

// File: rtl/gen2_bit_source.sv
// Picks the bit being encoded (pilot zero, preamble, payload or dummy one) and
// tracks the previous bit that Miller needs for its boundary inversion.
module gen2_bit_source
    import gen2_mod_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       init,
    input  logic       tick,
    input  enc_state_t state,
    input  logic       miller,
    input  logic [2:0] pre_idx,
    input  logic       mc_first,
    input  logic       mc_last,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    output logic       cur_bit,
    output logic       prev_bit,
    output logic       pre_ovr,
    output logic       take
);

    logic data_q;
    logic prev_q;

    always_comb begin
        cur_bit = 1'b0;
        pre_ovr = 1'b0;
        take    = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                pre_ovr = !miller;
                cur_bit = MILLER_PREAMBLE[3'd5 - pre_idx];
            end
            ST_DATA: begin
                // A missing bit at the boundary becomes the first half of the dummy one.
                if (mc_first) begin
                    take    = i_bit_valid;
                    cur_bit = i_bit_valid ? i_bit : 1'b1;
                end else begin
                    cur_bit = data_q;
                end
            end
            ST_DUMMY: cur_bit = 1'b1;
            default:  cur_bit = 1'b0;
        endcase
    end

    assign prev_bit = prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            data_q <= 1'b0;
            prev_q <= 1'b0;
        end else if (init) begin
            data_q <= 1'b0;
            prev_q <= 1'b1;
        end else if (tick) begin
            if (take)
                data_q <= i_bit;
            if (mc_last)
                prev_q <= cur_bit;
        end
    end

endmodule

// File: rtl/gen2_backscatter_enc.sv
// Gen2 reply waveform generator: pilot, FM0/Miller preamble, handshaked payload and
// dummy-1, stepped one half-slot per BLF tick.
module gen2_backscatter_enc
    import gen2_mod_pkg::*;
#(
    parameter int MAX_M_LOG2     = 3,
    parameter int PILOT_FM0      = 12,
    parameter int PILOT_MILLER_S = 4,
    parameter int PILOT_MILLER_L = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en2blf_mod,
    input  logic [1:0] i_m_dec,
    input  logic       i_trext,
    input  logic       i_start,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    input  logic       i_bit_last,
    input  logic       i_clear_cu,
    output logic       o_bit_ready,
    output logic       o_data_mod,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_underrun
);

    localparam int MC_W     = MAX_M_LOG2 + 1;
    localparam int MAX_A    = (PILOT_FM0 > PILOT_MILLER_S) ? PILOT_FM0 : PILOT_MILLER_S;
    localparam int MAX_B    = (PILOT_MILLER_L > PRE_BITS) ? PILOT_MILLER_L : PRE_BITS;
    localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(CNT_MAX);

    enc_state_t       state;
    logic [MC_W-1:0]  mc;
    logic [MC_W-1:0]  mc_end;
    logic [MC_W-1:0]  mc_mid;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_end;
    logic [1:0]       m_log2;
    logic [1:0]       start_m;
    logic             trext_q;
    logic             last_q;
    logic             lvl;
    logic             miller;
    logic             mc_first;
    logic             mc_last;
    logic             init;
    logic             cur_bit;
    logic             prev_bit;
    logic             pre_ovr;
    logic             take;
    logic [3:0]       fm0_idx;
    logic             lvl_fm0;
    logic             lvl_mil;
    logic             lvl_next;
    logic             out_next;
    int               pilot_len;

    assign start_m  = clamp_m_log2(i_m_dec, MAX_M_LOG2);
    assign miller   = (m_log2 != M_DEC_FM0);
    assign mc_end   = {MC_W{1'b1}} >> (MAX_M_LOG2 - int'(m_log2));
    assign mc_mid   = MC_W'(1) << m_log2;
    assign mc_first = (mc == '0);
    assign mc_last  = (mc == mc_end);
    assign init     = (state == ST_IDLE) && i_start;

    assign pilot_len = miller ? (trext_q ? PILOT_MILLER_L : PILOT_MILLER_S) : PILOT_FM0;
    assign cnt_end   = (state == ST_PILOT) ? CNT_W'(pilot_len - 1) : CNT_W'(PRE_BITS - 1);

    gen2_bit_source u_bit_source (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (i_clear_cu),
        .init        (init),
        .tick        (i_en2blf_mod),
        .state       (state),
        .miller      (miller),
        .pre_idx     (bit_cnt[2:0]),
        .mc_first    (mc_first),
        .mc_last     (mc_last),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .cur_bit     (cur_bit),
        .prev_bit    (prev_bit),
        .pre_ovr     (pre_ovr),
        .take        (take)
    );

    assign o_bit_ready = rst_n && i_en2blf_mod && !i_clear_cu && take;

    // FM0 preamble is a literal half-slot pattern; everything else follows the coding rules.
    assign fm0_idx  = {bit_cnt[2:0], mc[0]};
    assign lvl_fm0  = pre_ovr ? FM0_PREAMBLE[4'd11 - fm0_idx]
                              : lvl ^ mc_first ^ ((mc == MC_W'(1)) && !cur_bit);
    assign lvl_mil  = lvl ^ (mc_first && !prev_bit && !cur_bit) ^ ((mc == mc_mid) && cur_bit);
    assign lvl_next = miller ? lvl_mil : lvl_fm0;
    assign out_next = lvl_next ^ (miller && mc[0]);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear_cu) begin
            state      <= ST_IDLE;
            mc         <= '0;
            bit_cnt    <= '0;
            m_log2     <= M_DEC_FM0;
            trext_q    <= 1'b0;
            last_q     <= 1'b0;
            lvl        <= 1'b0;
            o_data_mod <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_underrun <= 1'b0;
            if (state == ST_IDLE) begin
                if (i_start) begin
                    m_log2  <= start_m;
                    trext_q <= i_trext;
                    last_q  <= 1'b0;
                    mc      <= '0;
                    bit_cnt <= '0;
                    lvl     <= (start_m != M_DEC_FM0);
                    o_busy  <= 1'b1;
                    state   <= ((start_m != M_DEC_FM0) || i_trext) ? ST_PILOT : ST_PREAMBLE;
                end
            end else if (i_en2blf_mod) begin
                if (state == ST_DONE) begin
                    state      <= ST_IDLE;
                    lvl        <= 1'b0;
                    mc         <= '0;
                    o_data_mod <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b1;
                end else begin
                    lvl        <= lvl_next;
                    o_data_mod <= out_next;
                    mc         <= mc_last ? '0 : mc + MC_W'(1);
                    case (state)
                        ST_PILOT, ST_PREAMBLE: begin
                            if (mc_last) begin
                                if (bit_cnt == cnt_end) begin
                                    bit_cnt <= '0;
                                    state   <= (state == ST_PILOT) ? ST_PREAMBLE : ST_DATA;
                                end else begin
                                    bit_cnt <= bit_cnt + CNT_W'(1);
                                end
                            end
                        end
                        ST_DATA: begin
                            if (mc_first) begin
                                if (take) begin
                                    last_q <= i_bit_last;
                                end else begin
                                    o_underrun <= 1'b1;
                                    state      <= ST_DUMMY;
                                end
                            end else if (mc_last && last_q) begin
                                state <= ST_DUMMY;
                            end
                        end
                        ST_DUMMY: begin
                            if (mc_last)
                                state <= ST_DONE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gen2_backscatter_enc.sv
// Directed bench for gen2_backscatter_enc with a half-slot scoreboard built from an
// independent FM0/Miller reference model.
module tb_gen2_backscatter_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en2blf_mod;
    logic [1:0] i_m_dec;
    logic       i_trext;
    logic       i_start;
    logic       i_bit;
    logic       i_bit_valid;
    logic       i_bit_last;
    logic       i_clear_cu;
    logic       o_bit_ready;
    logic       o_data_mod;
    logic       o_busy;
    logic       o_done;
    logic       o_underrun;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ur_cnt = 0;

    logic exp_lvl_q[$];
    logic exp_rdy_q[$];
    logic m_lvl;
    logic m_prev;

    logic [63:0] pl;
    int n_bits;
    int ur_at;
    int idx;
    int tick_no;
    int first_rdy;
    int rdy_cnt;

    gen2_backscatter_enc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en2blf_mod (i_en2blf_mod),
        .i_m_dec      (i_m_dec),
        .i_trext      (i_trext),
        .i_start      (i_start),
        .i_bit        (i_bit),
        .i_bit_valid  (i_bit_valid),
        .i_bit_last   (i_bit_last),
        .i_clear_cu   (i_clear_cu),
        .o_bit_ready  (o_bit_ready),
        .o_data_mod   (o_data_mod),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underrun   (o_underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_done)     done_cnt++;
        if (o_underrun) ur_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic l, input logic r);
        exp_lvl_q.push_back(l);
        exp_rdy_q.push_back(r);
    endtask

    task automatic fm0_bit(input logic v, input logic r);
        m_lvl = ~m_lvl;
        push(m_lvl, r);
        if (!v) m_lvl = ~m_lvl;
        push(m_lvl, 1'b0);
    endtask

    task automatic mil_bit(input int mlog, input logic v, input logic r);
        int m;
        m = 1 << mlog;
        if (!m_prev && !v) m_lvl = ~m_lvl;
        for (int h = 0; h < 2 * m; h++) begin
            if (h == m && v) m_lvl = ~m_lvl;
            push(m_lvl ^ h[0], r && (h == 0));
        end
        m_prev = v;
    endtask

    task automatic build(input int mlog, input logic trx, input int nb);
        logic [11:0] fp;
        logic [5:0]  mp;
        fp = 12'b110100100011;
        mp = 6'b010111;
        exp_lvl_q.delete();
        exp_rdy_q.delete();
        if (mlog == 0) begin
            m_lvl = 1'b0;
            if (trx) for (int i = 0; i < 12; i++) fm0_bit(1'b0, 1'b0);
            for (int i = 11; i >= 0; i--) begin
                m_lvl = fp[i];
                push(m_lvl, 1'b0);
            end
            for (int i = 0; i < nb; i++) fm0_bit(pl[i], 1'b1);
            fm0_bit(1'b1, 1'b0);
        end else begin
            m_lvl  = 1'b1;
            m_prev = 1'b1;
            for (int i = 0; i < (trx ? 16 : 4); i++) mil_bit(mlog, 1'b0, 1'b0);
            for (int i = 5; i >= 0; i--) mil_bit(mlog, mp[i], 1'b0);
            for (int i = 0; i < nb; i++) mil_bit(mlog, pl[i], 1'b1);
            mil_bit(mlog, 1'b1, 1'b0);
        end
        push(1'b0, 1'b0);
    endtask

    task automatic start(input logic [1:0] mdec, input logic trx);
        i_m_dec = mdec;
        i_trext = trx;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_busy", o_busy, 1);
    endtask

    task automatic tick_chk(input string tag, input int gap);
        logic el;
        logic er;
        i_bit        = pl[idx];
        i_bit_valid  = (idx < n_bits) && (idx != ur_at);
        i_bit_last   = (idx == n_bits - 1);
        i_en2blf_mod = 1'b1;
        #1;
        el = exp_lvl_q.pop_front();
        er = exp_rdy_q.pop_front();
        chk({tag, ":ready"}, o_bit_ready, er);
        if (o_bit_ready) begin
            idx++;
            rdy_cnt++;
            if (first_rdy < 0) first_rdy = tick_no;
        end
        tick_no++;
        @(negedge clk);
        i_en2blf_mod = 1'b0;
        chk({tag, ":lvl"}, o_data_mod, el);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk({tag, ":hold"}, o_data_mod, el);
        end
    endtask

    task automatic prep(input int nb, input int ur);
        n_bits    = nb;
        ur_at     = ur;
        idx       = 0;
        tick_no   = 0;
        first_rdy = -1;
        rdy_cnt   = 0;
    endtask

    task automatic run_reply(input string tag, input logic [1:0] mdec, input logic trx,
                             input int nb, input int ur, input int max_gap, input logic chg);
        int d0;
        int u0;
        int consumed;
        consumed = (ur >= 0) ? ur : nb;
        prep(nb, ur);
        build(int'(mdec), trx, consumed);
        d0 = done_cnt;
        u0 = ur_cnt;
        start(mdec, trx);
        if (chg) begin
            i_m_dec = ~mdec;
            i_trext = ~trx;
        end
        while (exp_lvl_q.size() > 0)
            tick_chk(tag, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        repeat (2) @(negedge clk);
        chk({tag, ":busy_end"}, o_busy, 0);
        chk({tag, ":done_pulses"}, done_cnt - d0, 1);
        chk({tag, ":underruns"}, ur_cnt - u0, (ur >= 0) ? 1 : 0);
        chk({tag, ":ready_pulses"}, rdy_cnt, consumed);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":data_mod"}, o_data_mod, 0);
        chk({tag, ":busy"}, o_busy, 0);
        chk({tag, ":done"}, o_done, 0);
        chk({tag, ":underrun"}, o_underrun, 0);
        chk({tag, ":bit_ready"}, o_bit_ready, 0);
    endtask

    task automatic idle_tick(input string tag);
        i_bit_valid  = 1'b1;
        i_en2blf_mod = 1'b1;
        #1;
        chk({tag, ":ready"}, o_bit_ready, 0);
        @(negedge clk);
        i_en2blf_mod = 1'b0;
        chk({tag, ":lvl"}, o_data_mod, 0);
        chk({tag, ":busy"}, o_busy, 0);
    endtask

    initial begin
        int d0;
        rst_n        = 1'b0;
        i_en2blf_mod = 1'b0;
        i_m_dec      = 2'b00;
        i_trext      = 1'b0;
        i_start      = 1'b0;
        i_bit        = 1'b0;
        i_bit_valid  = 1'b0;
        i_bit_last   = 1'b0;
        i_clear_cu   = 1'b0;
        pl           = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // FM0, no pilot, payload 1 then 0 (last)
        pl = 64'h1;
        run_reply("fm0_basic", 2'b00, 1'b0, 2, -1, 0, 1'b0);

        // M=2 short pilot: first ready after 40 half-slots
        pl = 64'hA5;
        run_reply("m2_pilot", 2'b01, 1'b0, 8, -1, 0, 1'b0);
        chk("m2_first_ready", first_rdy, 40);

        // M=8 long pilot, random payload, irregular tick spacing
        pl = {32'h0, $urandom};
        run_reply("m8_rand", 2'b11, 1'b1, 32, -1, 3, 1'b0);

        // FM0 pilot with gaps
        pl = {32'h0, $urandom};
        run_reply("fm0_trext", 2'b00, 1'b1, 16, -1, 2, 1'b0);

        // Underrun at the third payload boundary
        pl = 64'h1B;
        run_reply("m4_underrun", 2'b10, 1'b0, 5, 2, 1, 1'b0);

        // Clear in the middle of the FM0 preamble, with a concurrent start request
        d0 = done_cnt;
        prep(0, -1);
        build(0, 1'b0, 0);
        start(2'b00, 1'b0);
        for (int i = 0; i < 4; i++) tick_chk("clr_pre", 0);
        chk("clr_pre_level", o_data_mod, 1);
        i_clear_cu = 1'b1;
        i_start    = 1'b1;
        @(negedge clk);
        i_clear_cu = 1'b0;
        i_start    = 1'b0;
        chk_all_zero("after_clear");
        for (int i = 0; i < 3; i++) idle_tick("clr_idle");
        chk("clr_no_done", done_cnt - d0, 0);

        // Start and clear together in IDLE: clear wins
        i_start    = 1'b1;
        i_clear_cu = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
        i_clear_cu = 1'b0;
        chk("start_vs_clear_busy", o_busy, 0);

        pl = 64'h6;
        run_reply("fm0_after_clr", 2'b00, 1'b1, 4, -1, 0, 1'b0);

        // Reset asserted while payload is streaming
        pl = 64'hC3;
        prep(8, -1);
        build(2, 1'b0, 8);
        start(2'b10, 1'b0);
        while (idx < 3 && exp_lvl_q.size() > 0) tick_chk("rst_data", 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("after_rst");
        for (int i = 0; i < 3; i++) idle_tick("rst_idle");
        exp_lvl_q.delete();
        exp_rdy_q.delete();

        // Encoding and pilot inputs change while busy
        pl = 64'h2D;
        run_reply("m4_mdec_chg", 2'b10, 1'b0, 6, -1, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
